run_detect_n: RTL and testbench



---
 rtl/run_detect_pkg.sv | 18 +
 rtl/run_detect_n_sat_counter.sv | 34 +++
 rtl/run_detect_n.sv | 95 +++++++++
 tb/tb_run_detect_n.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/run_detect_pkg.sv
// ---------------------------------------------------------------------------
// run_detect_pkg
// Shared definitions for the run-length detector family.
//   MODE_*   : polarity-mode encodings on the 2-bit mode input.
//   sat_min  : saturating minimum. It clamps a run length to its ceiling.
// ---------------------------------------------------------------------------
package run_detect_pkg;

    localparam logic [1:0] MODE_BOTH  = 2'b00;
    localparam logic [1:0] MODE_ONES  = 2'b01;
    localparam logic [1:0] MODE_ZEROS = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;

    function automatic int unsigned sat_min(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/run_detect_n_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk : rising-edge clock
//   rst : synchronous, active-low reset
//   clr : synchronous clear. It has priority over inc.
//   inc : count enable. Adds one per cycle and stops at all-ones.
//   q   : registered count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/run_detect_n.sv
// ---------------------------------------------------------------------------
// run_detect_n
// Mealy detector for RUN_LEN consecutive identical bits on a serial input.
// Detection overlaps: after a run reaches RUN_LEN, each further equal bit
// produces another hit.
//   clk     : rising-edge clock
//   rst     : synchronous, active-low reset
//   en      : sample qualifier. x is consumed only when en=1.
//   x       : serial data bit
//   mode    : 00 both polarities, 01 ones, 10 zeros, 11 masked
//   clr     : synchronous clear of hit_cnt
//   y       : hit flag. It is combinational from state, x, en and mode.
//   y_bit   : polarity of the current hit. It is 0 when there is no hit.
//   run_len : registered length of the current run, saturating at RUN_LEN
//   hit_cnt : registered hit count, saturating at all-ones
// ---------------------------------------------------------------------------
module run_detect_n
    import run_detect_pkg::*;
#(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8,
    parameter int RL_W    = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             y,
    output logic             y_bit,
    output logic [RL_W-1:0]  run_len,
    output logic [CNT_W-1:0] hit_cnt
);

    logic            r_last_bit;
    logic [RL_W-1:0] r_run_len;

    // The effective length is one bit wider than the stored length.
    // run_len+1 then cannot wrap when run_len already equals RUN_LEN.
    logic [RL_W:0]   w_eff;
    logic            w_len_hit;
    logic            w_mode_ok;
    logic            w_y;
    logic [RL_W-1:0] w_run_len_next;

    // A zero run_len means there is no history. The first sampled bit then
    // starts a new run, whatever last_bit holds.
    assign w_eff = ((r_run_len != '0) && (x == r_last_bit))
                 ? ({1'b0, r_run_len} + (RL_W+1)'(1))
                 : (RL_W+1)'(1);

    assign w_len_hit = (w_eff >= (RL_W+1)'(RUN_LEN));

    always_comb begin
        w_mode_ok = 1'b0;
        case (mode)
            MODE_BOTH:  w_mode_ok = 1'b1;
            MODE_ONES:  w_mode_ok = x;
            MODE_ZEROS: w_mode_ok = ~x;
            default:    w_mode_ok = 1'b0;
        endcase
    end

    assign w_y   = en & rst & w_mode_ok & w_len_hit;
    assign y     = w_y;
    assign y_bit = w_y & x;

    assign w_run_len_next = RL_W'(sat_min(int'(unsigned'(w_eff)), RUN_LEN));

    // Run tracking does not depend on mode. A masked or wrong-polarity bit
    // still extends or restarts the run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_bit <= 1'b0;
            r_run_len  <= '0;
        end else if (en) begin
            r_last_bit <= x;
            r_run_len  <= w_run_len_next;
        end
    end

    assign run_len = r_run_len;

    sat_counter #(
        .W (CNT_W)
    ) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_y),
        .q   (hit_cnt)
    );

endmodule

// File: tb/tb_run_detect_n.sv
// ---------------------------------------------------------------------------
// tb_run_detect_n
// Directed bench with three detector instances that share one set of inputs:
//   A: RUN_LEN=3, CNT_W=8   B: RUN_LEN=3, CNT_W=2   C: RUN_LEN=1, CNT_W=8
// The bench compares one instance at a time, selected by sel.
// Expected y/y_bit values are queued when a bit is driven. They are popped
// and compared while the Mealy output for that bit is valid.
// ---------------------------------------------------------------------------
module tb_run_detect_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       x   = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       clr = 1'b0;

    logic       y_a, yb_a, y_b, yb_b, y_c, yb_c;
    logic [1:0] rl_a, rl_b;
    logic [0:0] rl_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;

    int sel = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        string tag;
        logic  y;
        logic  yb;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    run_detect_n #(.RUN_LEN(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .x(x), .mode(mode), .clr(clr),
        .y(y_a), .y_bit(yb_a), .run_len(rl_a), .hit_cnt(cnt_a));

    run_detect_n #(.RUN_LEN(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .x(x), .mode(mode), .clr(clr),
        .y(y_b), .y_bit(yb_b), .run_len(rl_b), .hit_cnt(cnt_b));

    run_detect_n #(.RUN_LEN(1), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .en(en), .x(x), .mode(mode), .clr(clr),
        .y(y_c), .y_bit(yb_c), .run_len(rl_c), .hit_cnt(cnt_c));

    // Outputs of the instance under comparison
    logic       s_y, s_yb;
    logic [7:0] s_cnt;
    logic [1:0] s_rl;
    always_comb begin
        s_y   = y_a;
        s_yb  = yb_a;
        s_cnt = cnt_a;
        s_rl  = rl_a;
        if (sel == 1) begin
            s_y = y_b; s_yb = yb_b; s_cnt = {6'b0, cnt_b}; s_rl = rl_b;
        end else if (sel == 2) begin
            s_y = y_c; s_yb = yb_c; s_cnt = cnt_c; s_rl = {1'b0, rl_c};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
            $display("check %s obs=%0h exp=%0h ok", tag, obs, expv);
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives one bit and queues its expected Mealy response. The response
    // is popped and checked before the sampling edge.
    task automatic step(input string tag, input logic xi, input logic ei,
                        input logic [1:0] mi, input logic ci,
                        input logic ey, input logic eyb);
        exp_t e;
        @(negedge clk);
        x = xi; en = ei; mode = mi; clr = ci;
        exp_q.push_back('{tag, ey, eyb});
        #1;
        e = exp_q.pop_front();
        check({e.tag, "_y"},    32'(s_y),  32'(e.y));
        check({e.tag, "_ybit"}, 32'(s_yb), 32'(e.yb));
    endtask

    // Samples registered outputs just after the edge that consumed the last step.
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0; en = 1'b1; x = 1'b1; clr = 1'b0; mode = 2'b00;
        #1;
        check({tag, "_y_in_rst"}, 32'(s_y), 32'd0);
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        #1;
        check({tag, "_rl0"},  32'(s_rl),  32'd0);
        check({tag, "_cnt0"}, 32'(s_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic s1x [7];
        logic s1y_both [7];
        logic s1y_ones [7];
        logic s1y_zero [7];
        logic cx [4];
        logic cy [4];
        s1x      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        s1y_both = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        s1y_ones = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        s1y_zero = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cx       = '{1'b0, 1'b1, 1'b1, 1'b0};
        cy       = '{1'b0, 1'b1, 1'b1, 1'b0};

        // ---- Instance A, RUN_LEN=3 ----
        sel = 0;
        do_reset("a_rst");

        for (int i = 0; i < 7; i++)
            step($sformatf("both%0d", i), s1x[i], 1'b1, 2'b00, 1'b0,
                 s1y_both[i], s1y_both[i] & s1x[i]);
        after_edge();
        check("both_cnt", 32'(s_cnt), 32'd3);
        check("both_rl",  32'(s_rl),  32'd3);

        do_reset("a_rst2");
        for (int i = 0; i < 7; i++)
            step($sformatf("ones%0d", i), s1x[i], 1'b1, 2'b01, 1'b0,
                 s1y_ones[i], s1y_ones[i] & s1x[i]);
        after_edge();
        check("ones_cnt", 32'(s_cnt), 32'd2);

        do_reset("a_rst3");
        for (int i = 0; i < 7; i++)
            step($sformatf("zero%0d", i), s1x[i], 1'b1, 2'b10, 1'b0,
                 s1y_zero[i], 1'b0);
        after_edge();
        check("zero_cnt", 32'(s_cnt), 32'd1);

        // en=0 gap: the run holds and resumes after the gap
        do_reset("a_rst4");
        step("gap0", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step("gap1", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step("gap2", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        after_edge();
        check("gap_rl", 32'(s_rl), 32'd2);
        step("gap3", 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);

        // Reset mid-run discards the run history
        do_reset("a_rst5");
        step("mr0", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step("mr1", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        do_reset("a_mid");
        step("mr2", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step("mr3", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step("mr4", 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        after_edge();
        check("mr_cnt", 32'(s_cnt), 32'd1);

        // Masked mode still tracks the run. Unmasking hits immediately.
        do_reset("a_rst6");
        step("msk0", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step("msk1", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step("msk2", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step("msk3", 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);
        after_edge();
        check("msk_cnt", 32'(s_cnt), 32'd1);

        // ---- Instance B, CNT_W=2 saturation and clear priority ----
        sel = 1;
        do_reset("b_rst");
        for (int i = 0; i < 8; i++)
            step($sformatf("sat%0d", i), 1'b0, 1'b1, 2'b00, 1'b0,
                 (i >= 2) ? 1'b1 : 1'b0, 1'b0);
        after_edge();
        check("sat_cnt", 32'(s_cnt), 32'd3);
        step("clr_hit", 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
        after_edge();
        check("clr_cnt", 32'(s_cnt), 32'd0);
        step("post_clr", 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        after_edge();
        check("post_clr_cnt", 32'(s_cnt), 32'd1);

        // ---- Instance C, RUN_LEN=1 ----
        sel = 2;
        do_reset("c_rst");
        for (int i = 0; i < 4; i++)
            step($sformatf("rl1_%0d", i), cx[i], 1'b1, 2'b01, 1'b0, cy[i], cy[i] & cx[i]);
        after_edge();
        check("rl1_cnt", 32'(s_cnt), 32'd2);

        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
